// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, byte-masked BRAM.
// Optional window check on accepted addresses: define BRAM_ARB_RANGE_CHECK_EN.
module bram_arbiter #(
    parameter logic [31:0] BASE_MEMORY = 32'h0000_0000,
    parameter logic [31:0] TOP_MEMORY  = 32'h0000_07ff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_valid,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    input  logic        m0_req_we,
    input  logic [3:0]  m0_req_mask,
    output logic        m0_req_ready,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,
    input  logic        m1_req_valid,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    input  logic        m1_req_we,
    input  logic [3:0]  m1_req_mask,
    output logic        m1_req_ready,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic [3:0]  byteMask,
    input  logic [31:0] memReadData,
    output logic        busy
);

`ifdef BRAM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        grant_id;
    logic        accept;
    logic [31:0] sel_addr;
    logic        sel_oor;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic [3:0]  lat_mask;
    logic        lat_id;
    logic        lat_err;
    logic [31:0] rsp_data;

    // Ready depends only on state, valids and last_grant; held low during reset
    // so nothing is considered accepted on a reset edge.
    always_comb begin
        state_nxt    = state;
        grant_id     = 1'b0;
        accept       = 1'b0;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req_valid && m1_req_valid) grant_id = ~last_grant;
                else                              grant_id = m1_req_valid;
                if (rst_n && (m0_req_valid || m1_req_valid)) begin
                    accept       = 1'b1;
                    m0_req_ready = ~grant_id;
                    m1_req_ready = grant_id;
                    state_nxt    = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_addr = grant_id ? m1_req_addr : m0_req_addr;
    // Full-width compare so high addresses never alias into the window.
    assign sel_oor  = RANGE_CHECK && ((sel_addr < BASE_MEMORY) || (sel_addr > TOP_MEMORY));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_mask   <= '0;
            lat_id     <= 1'b0;
            lat_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant_id;
                lat_id     <= grant_id;
                lat_addr   <= sel_addr;
                lat_wdata  <= grant_id ? m1_req_wdata : m0_req_wdata;
                lat_we     <= grant_id ? m1_req_we    : m0_req_we;
                lat_mask   <= grant_id ? m1_req_mask  : m0_req_mask;
                lat_err    <= sel_oor;
            end
        end
    end

    assign memAddress   = {lat_addr[31:2], 2'b00};
    assign memWriteData = lat_wdata;
    assign byteMask     = (state == ACCESS) ? lat_mask : 4'h0;
    assign memWrite     = (state == ACCESS) && lat_we && !lat_err;
    assign busy         = (state != IDLE);

    // Writes and rejected accesses answer with zero data.
    assign rsp_data     = (state == RESP && !lat_we && !lat_err) ? memReadData : 32'h0;

    assign m0_rsp_valid = (state == RESP) && !lat_id;
    assign m1_rsp_valid = (state == RESP) &&  lat_id;
    assign m0_rsp_rdata = m0_rsp_valid ? rsp_data : 32'h0;
    assign m1_rsp_rdata = m1_rsp_valid ? rsp_data : 32'h0;
    assign m0_rsp_err   = m0_rsp_valid && lat_err;
    assign m1_rsp_err   = m1_rsp_valid && lat_err;

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized bench for bram_arbiter: BRAM model, transaction-level scoreboard, directed cases.
module tb_bram_arbiter;

`ifdef BRAM_ARB_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld[2];
    logic [31:0] adr[2];
    logic [31:0] wd[2];
    logic        we[2];
    logic [3:0]  msk[2];
    logic        rdy[2];
    logic        rv[2];
    logic [31:0] rd[2];
    logic        er[2];
    logic [31:0] memAddress, memWriteData, memReadData;
    logic        memWrite, busy;
    logic [3:0]  byteMask;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(vld[0]), .m0_req_addr(adr[0]), .m0_req_wdata(wd[0]), .m0_req_we(we[0]),
        .m0_req_mask(msk[0]), .m0_req_ready(rdy[0]), .m0_rsp_valid(rv[0]), .m0_rsp_rdata(rd[0]),
        .m0_rsp_err(er[0]),
        .m1_req_valid(vld[1]), .m1_req_addr(adr[1]), .m1_req_wdata(wd[1]), .m1_req_we(we[1]),
        .m1_req_mask(msk[1]), .m1_req_ready(rdy[1]), .m1_rsp_valid(rv[1]), .m1_rsp_rdata(rd[1]),
        .m1_rsp_err(er[1]),
        .memAddress(memAddress), .memWriteData(memWriteData), .memWrite(memWrite),
        .byteMask(byteMask), .memReadData(memReadData), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h5A3C_96E1;
    endfunction

    // BRAM: 2 KiB window, registered read, out-of-window writes dropped, reads return 0
    logic [31:0] bram[512];
    always @(posedge clk) begin
        if (memWrite && memAddress <= 32'h7ff)
            for (int b = 0; b < 4; b++)
                if (byteMask[b]) bram[memAddress[10:2]][8*b +: 8] <= memWriteData[8*b +: 8];
        memReadData <= (memAddress <= 32'h7ff) ? bram[memAddress[10:2]] : 32'h0;
    end

    // Reference: one transaction at a time, 3 cycles each, alternating on ties
    logic [31:0] ref_mem[512];
    int          bcnt = 0;
    int          lastg = 1;
    int          pid = 0;
    logic [31:0] prd = '0;
    logic        perr = 1'b0;
    logic        pwe = 1'b0;
    int          grant_q[$];

    task automatic model_accept(input int g);
        logic [31:0] a;
        logic        inr;
        logic [8:0]  idx;
        a    = adr[g];
        inr  = (a <= 32'h7ff);
        idx  = a[10:2];
        pid  = g;
        pwe  = we[g];
        perr = RC && !inr;
        prd  = 32'h0;
        if (we[g]) begin
            if (inr)
                for (int b = 0; b < 4; b++)
                    if (msk[g][b]) ref_mem[idx][8*b +: 8] = wd[g][8*b +: 8];
        end else begin
            prd = inr ? ref_mem[idx] : 32'h0;
        end
        bcnt  = 2;
        lastg = g;
        grant_q.push_back(g);
    endtask

    always @(negedge clk) begin
        int g;
        g = -1;
        if (rst_n && bcnt == 0) begin
            if (vld[0] && vld[1]) g = 1 - lastg;
            else if (vld[0])      g = 0;
            else if (vld[1])      g = 1;
        end
        chk("ready0", 32'(rdy[0]), 32'(g == 0));
        chk("ready1", 32'(rdy[1]), 32'(g == 1));
        chk("rsp_valid0", 32'(rv[0]), 32'(bcnt == 1 && pid == 0));
        chk("rsp_valid1", 32'(rv[1]), 32'(bcnt == 1 && pid == 1));
        if (bcnt == 1) begin
            chk("rsp_rdata", rd[pid], prd);
            chk("rsp_err", 32'(er[pid]), 32'(perr));
        end
        chk("memWrite", 32'(memWrite), 32'(bcnt == 2 && pwe && !perr));
        chk("busy", 32'(busy), 32'(bcnt != 0));
        if (!rst_n) begin
            bcnt  = 0;
            lastg = 1;
        end else if (bcnt > 0) begin
            bcnt--;
        end else if (g >= 0) begin
            model_accept(g);
        end
    end

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0:       return 32'h7FC + 32'($urandom_range(0, 3));
            1:       return 32'h800 + 32'($urandom_range(0, 255));
            2:       return $urandom | 32'h8000_0000;
            default: return {21'd0, 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3))};
        endcase
    endfunction

    task automatic rand_req(input int p);
        vld[p] = 1'b1;
        adr[p] = rand_addr();
        wd[p]  = $urandom;
        we[p]  = 1'($urandom_range(0, 1));
        msk[p] = 4'($urandom_range(0, 15));
    endtask

    // Each port holds its request until accepted, then issues a new one with pct% chance.
    task automatic run_rand(input int ncyc, input int pct);
        logic acc[2];
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) acc[p] = vld[p] && rdy[p];
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++)
                if (!vld[p] || acc[p]) begin
                    if (int'($urandom_range(0, 99)) < pct) rand_req(p);
                    else vld[p] = 1'b0;
                end
        end
    endtask

    task automatic do_req(input int p, input logic [31:0] a, input logic [31:0] wv, input logic w,
                          input logic [3:0] m, output logic [31:0] rdat, output logic e,
                          output int wt, output int lat);
        @(posedge clk); #1;
        vld[p] = 1'b1; adr[p] = a; wd[p] = wv; we[p] = w; msk[p] = m;
        wt = 0;
        @(negedge clk);
        while (!rdy[p] && wt < 20) begin
            wt++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        vld[p] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv[p] && lat < 20);
        rdat = rd[p];
        e    = er[p];
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          wt, lat;
        for (int i = 0; i < 512; i++) begin
            bram[i]    <= init_word(i);
            ref_mem[i]  = init_word(i);
        end
        for (int p = 0; p < 2; p++) begin
            vld[p] = 1'b0; adr[p] = '0; wd[p] = '0; we[p] = 1'b0; msk[p] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // write then read back on m0
        do_req(0, 32'h100, 32'hDEAD_BEEF, 1'b1, 4'hF, r, e, wt, lat);
        chk("t1_wr_wait", 32'(wt), 32'd0);
        chk("t1_wr_lat", 32'(lat), 32'd2);
        chk("t1_wr_rdata", r, 32'h0);
        do_req(0, 32'h100, 32'h0, 1'b0, 4'h0, r, e, wt, lat);
        chk("t1_rd_lat", 32'(lat), 32'd2);
        chk("t1_rd_data", r, 32'hDEAD_BEEF);

        // single-lane write from m1
        do_req(1, 32'h104, 32'h1122_3344, 1'b1, 4'b0010, r, e, wt, lat);
        do_req(1, 32'h104, 32'h0, 1'b0, 4'h0, r, e, wt, lat);
        chk("t2_lane1", r, (init_word(65) & 32'hFFFF_00FF) | 32'h0000_3300);

        // both ports saturated: strict alternation from m0
        grant_q.delete();
        run_rand(24, 100);
        run_rand(40, 0);
        chk("t3_ngrants", 32'(grant_q.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < grant_q.size(); i++)
            chk($sformatf("t3_grant%0d", i), 32'(grant_q[i]), 32'(i % 2));

        // reset during an m1 write in ACCESS
        @(posedge clk); #1;
        vld[1] = 1'b1; adr[1] = 32'h200; wd[1] = 32'hA1B2_C3D4; we[1] = 1'b1; msk[1] = 4'hF;
        @(negedge clk);
        chk("t4_rdy1", 32'(rdy[1]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        vld[0] = 1'b1; adr[0] = 32'h204; we[0] = 1'b0;
        vld[1] = 1'b1; adr[1] = 32'h200; we[1] = 1'b0;
        @(negedge clk);
        chk("t4_mw_access", 32'(memWrite), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_mw_after", 32'(memWrite), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_no_rsp1", 32'(rv[1]), 32'd0);
        chk("t4_first_m0", 32'(rdy[0]), 32'd1);
        run_rand(40, 0);

        // window edges
        do_req(0, 32'h800, 32'h0, 1'b0, 4'h0, r, e, wt, lat);
        chk("t5_rdata", r, 32'h0);
        chk("t5_err", 32'(e), 32'(RC));
        do_req(1, 32'h800, 32'h5555_AAAA, 1'b1, 4'hF, r, e, wt, lat);
        chk("t5_wr_err", 32'(e), 32'(RC));
        do_req(0, 32'h7FC, 32'hCAFE_F00D, 1'b1, 4'hF, r, e, wt, lat);
        do_req(1, 32'h7FC, 32'h0, 1'b0, 4'h0, r, e, wt, lat);
        chk("t6_rdata", r, 32'hCAFE_F00D);
        chk("t6_err", 32'(e), 32'd0);

        // random traffic against the scoreboard
        grant_q.delete();
        run_rand(600, 50);
        run_rand(40, 0);
        chk("rand_progress", 32'(grant_q.size() > 50), 32'd1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
